// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop around
// an external oversampling bit sampler and presents validated bytes.
module uart_rx_frame_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  dat_samp_en,
   output logic [5:0]            edge_cnt,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  strt_glitch
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            p_q, p_d;
   logic [5:0]            edge_q, edge_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  valid_q, valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
   logic                  glitch_q, glitch_d;

   logic                  samp_pt;
   logic                  wrap;
   logic                  pres_ok;

   assign samp_pt = (edge_q == ((p_q >> 1) + 6'd1));
   assign wrap    = (edge_q == (p_q - 6'd1));
   assign pres_ok = (Prescale == 6'd8) ||
                    (Prescale == 6'd16) ||
                    (Prescale == 6'd32);

   // Next-state, counter, deserializer and flag logic
   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      edge_d    = 6'd0;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      p_data_d  = p_data_q;
      valid_d   = 1'b0;
      par_err_d = par_err_q;
      stp_err_d = stp_err_q;
      glitch_d  = 1'b0;
      if (state_q != S_IDLE) begin
         edge_d = wrap ? 6'd0 : edge_q + 6'd1;
      end
      unique case (state_q)
         S_IDLE: begin
            if (!RX_IN) begin
               state_d   = S_START;
               p_d       = pres_ok ? Prescale : 6'd8;
               par_err_d = 1'b0;
               stp_err_d = 1'b0;
               bit_cnt_d = 4'd0;
            end
         end
         S_START: begin
            if (samp_pt && sampled_bit) begin
               glitch_d = 1'b1;
               state_d  = S_IDLE;
               edge_d   = 6'd0;
            end else if (wrap) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (samp_pt) begin
               shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            end
            if (wrap) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(DATA_WIDTH - 1)) begin
                  state_d = PAR_EN ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (samp_pt) begin
               par_err_d = sampled_bit ^ (^shift_q) ^ PAR_TYP;
            end
            if (wrap) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (samp_pt) begin
               stp_err_d = ~sampled_bit;
               if (sampled_bit && !par_err_q) begin
                  p_data_d = shift_q;
                  valid_d  = 1'b1;
               end
               state_d = S_IDLE;
               edge_d  = 6'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         p_q       <= 6'd0;
         edge_q    <= 6'd0;
         bit_cnt_q <= 4'd0;
         shift_q   <= '0;
         p_data_q  <= '0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
         glitch_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         p_q       <= p_d;
         edge_q    <= edge_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         p_data_q  <= p_data_d;
         valid_q   <= valid_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
         glitch_q  <= glitch_d;
      end
   end

   assign dat_samp_en = (state_q != S_IDLE);
   assign edge_cnt    = edge_q;
   assign P_DATA      = p_data_q;
   assign data_valid  = valid_q;
   assign par_err     = par_err_q;
   assign stp_err     = stp_err_q;
   assign strt_glitch = glitch_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: drives serial frames, scoreboards
// expected bytes and valid-pulse cycles, checks flags and reset.
module tb_uart_rx_frame_ctrl;

   logic       CLK;
   logic       RST;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       sampled_bit;
   logic       dat_samp_en;
   logic [5:0] edge_cnt;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   glitch_cnt;
   int   glitch_cyc;

   // Ideal sampler: line value is stable at the mid-bit sample point
   assign sampled_bit = RX_IN;

   uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .Prescale    (Prescale),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .sampled_bit (sampled_bit),
      .dat_samp_en (dat_samp_en),
      .edge_cnt    (edge_cnt),
      .P_DATA      (P_DATA),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .strt_glitch (strt_glitch)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle counter, stepped on each active edge
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer and glitch pulse monitor
   always @(negedge CLK) begin
      if (data_valid) begin
         if (sb.size() == 0) begin
            chk("unexp_valid", data_valid, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("p_data", P_DATA, e.data);
            chk("valid_cyc", cyc, e.cyc);
            chk("valid_par_err", par_err, 1'b0);
            chk("valid_stp_err", stp_err, 1'b0);
         end
      end
      if (strt_glitch) begin
         glitch_cnt <= glitch_cnt + 1;
         glitch_cyc <= cyc;
      end
   end

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] data,
                             input logic [5:0] pres,
                             input int p,
                             input logic pe,
                             input logic pbit,
                             input logic sbit,
                             input int slen,
                             input logic push);
      int   c0;
      exp_t e;
      Prescale = pres;
      PAR_EN   = pe;
      c0       = cyc;
      if (push) begin
         e.data = data;
         e.cyc  = c0 + 1 + (9 + int'(pe)) * p + p / 2 + 2;
         sb.push_back(e);
      end
      RX_IN = 1'b0;
      repeat (p) @(negedge CLK);
      chk("start_en", dat_samp_en, 1'b1);
      chk("start_par_clr", par_err, 1'b0);
      chk("start_stp_clr", stp_err, 1'b0);
      for (int i = 0; i < 8; i++) begin
         RX_IN = data[i];
         repeat (p) @(negedge CLK);
      end
      if (pe) begin
         RX_IN = pbit;
         repeat (p) @(negedge CLK);
      end
      RX_IN = sbit;
      repeat (slen) @(negedge CLK);
      RX_IN = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, dat_samp_en, 1'b0);
      chk({tag, "_edge"}, edge_cnt, 6'd0);
      chk({tag, "_pdata"}, P_DATA, 8'h00);
      chk({tag, "_valid"}, data_valid, 1'b0);
      chk({tag, "_par"}, par_err, 1'b0);
      chk({tag, "_stp"}, stp_err, 1'b0);
      chk({tag, "_glitch"}, strt_glitch, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0;
      int g0;
      logic [7:0] d;
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      glitch_cnt = 0;
      glitch_cyc = -1;
      RST        = 1'b0;
      RX_IN      = 1'b1;
      Prescale   = 6'd8;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      repeat (3) @(negedge CLK);
      chk_zero("rst");
      RST = 1'b1;
      idle(5);

      // P=8, no parity, 0xA5
      send_frame(8'hA5, 6'd8, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      idle(4);
      chk("a5_drain", sb.size(), 0);
      chk("a5_pdata", P_DATA, 8'hA5);

      // P=16, even parity: good frame then bad parity bit
      PAR_TYP = 1'b0;
      send_frame(8'h3C, 6'd16, 16, 1'b1, 1'b0, 1'b1, 16, 1'b1);
      idle(4);
      chk("par_ok_drain", sb.size(), 0);
      send_frame(8'h3C, 6'd16, 16, 1'b1, 1'b1, 1'b1, 16, 1'b0);
      idle(4);
      chk("par_bad_err", par_err, 1'b1);
      chk("par_bad_pdata", P_DATA, 8'h3C);
      chk("par_bad_idle", dat_samp_en, 1'b0);

      // P=16, odd parity 0xC3 with parity bit 1
      PAR_TYP = 1'b1;
      send_frame(8'hC3, 6'd16, 16, 1'b1, 1'b1, 1'b1, 16, 1'b1);
      idle(4);
      chk("odd_drain", sb.size(), 0);
      chk("odd_par", par_err, 1'b0);
      PAR_TYP = 1'b0;
      PAR_EN  = 1'b0;

      // P=8 start glitch
      Prescale = 6'd8;
      g0 = glitch_cnt;
      c0 = cyc;
      RX_IN = 1'b0;
      repeat (3) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (20) @(negedge CLK);
      chk("glitch_cnt", glitch_cnt, g0 + 1);
      chk("glitch_cyc", glitch_cyc, c0 + 7);
      chk("glitch_idle", dat_samp_en, 1'b0);
      chk("glitch_pdata", P_DATA, 8'hC3);

      // P=32 stop error, line returns high after the stop sample
      send_frame(8'h81, 6'd32, 32, 1'b0, 1'b0, 1'b0, 19, 1'b0);
      idle(6);
      chk("stp_err_set", stp_err, 1'b1);
      chk("stp_err_pdata", P_DATA, 8'hC3);
      chk("stp_err_idle", dat_samp_en, 1'b0);
      send_frame(8'h55, 6'd32, 32, 1'b0, 1'b0, 1'b1, 32, 1'b1);
      idle(4);
      chk("s55_drain", sb.size(), 0);
      chk("s55_stp", stp_err, 1'b0);

      // P=8 back-to-back frames
      g0 = glitch_cnt;
      send_frame(8'h12, 6'd8, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      send_frame(8'hEF, 6'd8, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      idle(6);
      chk("b2b_drain", sb.size(), 0);
      chk("b2b_pdata", P_DATA, 8'hEF);
      chk("b2b_glitch", glitch_cnt, g0);

      // Unsupported prescale falls back to 8
      send_frame(8'h3A, 6'd12, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      idle(4);
      chk("pres12_drain", sb.size(), 0);

      // Reset during data bit 4 of 0x7E
      d = 8'h7E;
      Prescale = 6'd8;
      RX_IN = 1'b0;
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         RX_IN = d[i];
         repeat (8) @(negedge CLK);
      end
      RX_IN = d[4];
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge CLK);
      RX_IN = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      idle(20);
      chk("post_rst_idle", dat_samp_en, 1'b0);
      send_frame(8'h01, 6'd8, 8, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      idle(20);
      chk("final_drain", sb.size(), 0);
      chk("final_pdata", P_DATA, 8'h01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
